// File: rtl/counter_seq_ctrl.sv
// Purpose: turns "optionally reset, then advance N steps" commands into non-overlapping counter requests.
// Latency: DONE in cycle k+1+R*(RST_CYC+GAP_CYC)+N*(PULSE_CYC+GAP_CYC) after acceptance at edge k.
// Backpressure: CMD_READY only in IDLE; CMD_VALID while busy is ignored and must be held by the requester.
module counter_seq_ctrl #(
    parameter int PULSE_CYC = 2,
    parameter int RST_CYC   = 3,
    parameter int GAP_CYC   = 2,
    parameter int STEP_W    = 16,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_RESET,
    input  logic [STEP_W-1:0] CMD_STEPS,
    output logic              ADVANCE_COUNTER,
    output logic              RESET_COUNTER,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  SHADOW_COUNT
);

    // The timer only ever holds (duration - 1), so it is sized for the longest phase.
    localparam int MAX_A   = (PULSE_CYC > RST_CYC) ? PULSE_CYC : RST_CYC;
    localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LD   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_PULSE,
        S_RST_GAP,
        S_ADV_PULSE,
        S_ADV_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic               done_q, done_d;

    // Requests are pure state decodes, so the two can never be high together.
    assign ADVANCE_COUNTER = (state_q == S_ADV_PULSE);
    assign RESET_COUNTER   = (state_q == S_RST_PULSE);
    assign BUSY            = (state_q != S_IDLE);
    assign DONE            = done_q;
    assign SHADOW_COUNT    = shadow_q;
    assign CMD_READY       = (state_q == S_IDLE) & ~RST;

    // Next-state: phase timing, step bookkeeping, shadow count and completion pulse.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        steps_d  = steps_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    steps_d = CMD_STEPS;
                    if (CMD_RESET) begin
                        state_d = S_RST_PULSE;
                        timer_d = RST_LD;
                    end else if (CMD_STEPS != '0) begin
                        state_d = S_ADV_PULSE;
                        timer_d = PULSE_LD;
                    end else begin
                        // Zero-step command without reset completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            S_RST_PULSE: begin
                if (timer_q == '0) begin
                    state_d  = S_RST_GAP;
                    timer_d  = GAP_LD;
                    shadow_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_RST_GAP: begin
                if (timer_q == '0) begin
                    if (steps_q != '0) begin
                        state_d = S_ADV_PULSE;
                        timer_d = PULSE_LD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_ADV_PULSE: begin
                if (timer_q == '0) begin
                    state_d  = S_ADV_GAP;
                    timer_d  = GAP_LD;
                    // Count the step as soon as the pulse ends; shadow wraps silently.
                    shadow_d = shadow_q + CNT_W'(1);
                    steps_d  = steps_q - STEP_W'(1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_ADV_GAP: begin
                if (timer_q == '0) begin
                    if (steps_q != '0) begin
                        state_d = S_ADV_PULSE;
                        timer_d = PULSE_LD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation and clears the shadow count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            steps_q  <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            steps_q  <= steps_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Purpose: scoreboard bench for counter_seq_ctrl; default instance plus a 4-bit shadow instance.
// Latency: expected events are stamped with absolute cycle numbers relative to acceptance.
// Backpressure: commands are held valid until the selected instance shows CMD_READY.
module tb_counter_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_reset;
    logic [15:0] cmd_steps;

    logic        rdy_a, adv_a, rc_a, busy_a, done_a;
    logic [15:0] sh_a;
    logic        rdy_b, adv_b, rc_b, busy_b, done_b;
    logic [3:0]  sh_b;

    logic        m_rdy, m_adv, m_rc, m_done;
    logic [15:0] m_sh;

    always #5 clk = ~clk;

    counter_seq_ctrl u_a (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid & ~sel), .CMD_READY(rdy_a),
        .CMD_RESET(cmd_reset), .CMD_STEPS(cmd_steps), .ADVANCE_COUNTER(adv_a),
        .RESET_COUNTER(rc_a), .BUSY(busy_a), .DONE(done_a), .SHADOW_COUNT(sh_a)
    );

    counter_seq_ctrl #(.CNT_W(4)) u_b (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid & sel), .CMD_READY(rdy_b),
        .CMD_RESET(cmd_reset), .CMD_STEPS(cmd_steps), .ADVANCE_COUNTER(adv_b),
        .RESET_COUNTER(rc_b), .BUSY(busy_b), .DONE(done_b), .SHADOW_COUNT(sh_b)
    );

    always_comb begin
        m_rdy  = sel ? rdy_b  : rdy_a;
        m_adv  = sel ? adv_b  : adv_a;
        m_rc   = sel ? rc_b   : rc_a;
        m_done = sel ? done_b : done_a;
        m_sh   = sel ? {12'b0, sh_b} : sh_a;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        bit          adv;
        bit          rc;
        bit          done;
        logic [15:0] sh;
    } ev_t;

    ev_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [15:0] prev_sh;

    task automatic push_ev(input int c, input bit a, input bit r, input bit d, input logic [15:0] s);
        ev_t e;
        e.c = c; e.adv = a; e.rc = r; e.done = d; e.sh = s;
        sb.push_back(e);
    endtask

    task automatic adv_pair(input int c, input logic [15:0] s);
        push_ev(c, 1, 0, 0, s);
        push_ev(c + 1, 1, 0, 0, s);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    // Monitor: any request, DONE or shadow change is an event popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_adv && m_rc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL overlap cyc=%0d adv=1 rst=1 required not both high", cyc);
            end
            if (m_adv || m_rc || m_done || (m_sh !== prev_sh)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d adv=%0b rst=%0b done=%0b sh=%0d required no event",
                             cyc, m_adv, m_rc, m_done, m_sh);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (e.c != cyc || e.adv != m_adv || e.rc != m_rc || e.done != m_done || e.sh !== m_sh) begin
                        n_bad++;
                        $display("FAIL event got cyc=%0d adv=%0b rst=%0b done=%0b sh=%0d required cyc=%0d adv=%0b rst=%0b done=%0b sh=%0d",
                                 cyc, m_adv, m_rc, m_done, m_sh, e.c, e.adv, e.rc, e.done, e.sh);
                    end
                end
            end
            prev_sh = m_sh;
        end
    end

    // Present a command and hold it until accepted; k is the acceptance cycle.
    task automatic send(input bit r, input logic [15:0] n, output int k);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_reset = r;
        cmd_steps = n;
        while (!m_rdy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!m_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout got ready=0 required ready=1 within 3000 cycles");
            k = -1;
            cmd_valid = 1'b0;
            return;
        end
        k = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for all expected events, then idle a few cycles to catch stray ones.
    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout got pending=%0d required pending=0", sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int k2;
        rst       = 1'b1;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        cmd_steps = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", rdy_a, 0);
        chk("rst_ready_b", rdy_b, 0);
        chk("rst_adv", adv_a, 0);
        chk("rst_rstreq", rc_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_shadow_a", sh_a, 0);
        chk("rst_shadow_b", sh_b, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", rdy_a, 1);
        prev_sh = m_sh;
        mon_en  = 1'b1;

        // Plain advance of 3, with the next command held valid throughout.
        @(negedge clk);
        send(0, 16'd3, k);
        adv_pair(k + 1, 0);  push_ev(k + 3, 0, 0, 0, 1);
        adv_pair(k + 5, 1);  push_ev(k + 7, 0, 0, 0, 2);
        adv_pair(k + 9, 2);  push_ev(k + 11, 0, 0, 0, 3);
        push_ev(k + 13, 0, 0, 1, 3);
        send(0, 16'd1, k2);
        chk("held_cmd_accept_cycle", k2, k + 13);
        adv_pair(k2 + 1, 3); push_ev(k2 + 3, 0, 0, 0, 4);
        push_ev(k2 + 5, 0, 0, 1, 4);
        drain();

        // Reset then advance 2.
        @(negedge clk);
        send(1, 16'd2, k);
        push_ev(k + 1, 0, 1, 0, 4); push_ev(k + 2, 0, 1, 0, 4); push_ev(k + 3, 0, 1, 0, 4);
        push_ev(k + 4, 0, 0, 0, 0);
        adv_pair(k + 6, 0);  push_ev(k + 8, 0, 0, 0, 1);
        adv_pair(k + 10, 1); push_ev(k + 12, 0, 0, 0, 2);
        push_ev(k + 14, 0, 0, 1, 2);
        drain();

        // Zero steps, then reset-only presented in the DONE cycle.
        @(negedge clk);
        send(0, 16'd0, k);
        push_ev(k + 1, 0, 0, 1, 2);
        send(1, 16'd0, k2);
        chk("b2b_accept_cycle", k2, k + 1);
        push_ev(k2 + 1, 0, 1, 0, 2); push_ev(k2 + 2, 0, 1, 0, 2); push_ev(k2 + 3, 0, 1, 0, 2);
        push_ev(k2 + 4, 0, 0, 0, 0);
        push_ev(k2 + 6, 0, 0, 1, 0);
        drain();

        // Reset mid-operation during the second advance pulse.
        @(negedge clk);
        send(0, 16'd5, k);
        adv_pair(k + 1, 0);  push_ev(k + 3, 0, 0, 0, 1);
        adv_pair(k + 5, 1);
        push_ev(k + 7, 0, 0, 0, 0);
        while (cyc != k + 6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_adv", adv_a, 0);
        chk("midrst_shadow", sh_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_ready", rdy_a, 1);
        chk("midrst_done", done_a, 0);
        repeat (20) @(posedge clk);
        drain();

        // 4-bit shadow: preset to 14, then 3 steps wrap through 15, 0, 1.
        sel = 1'b1;
        @(negedge clk);
        send(0, 16'd14, k);
        for (int i = 0; i < 14; i++) begin
            adv_pair(k + 1 + 4 * i, 16'(i));
            push_ev(k + 3 + 4 * i, 0, 0, 0, 16'(i + 1));
        end
        push_ev(k + 57, 0, 0, 1, 14);
        send(0, 16'd3, k2);
        chk("wrap_accept_cycle", k2, k + 57);
        adv_pair(k2 + 1, 14); push_ev(k2 + 3, 0, 0, 0, 15);
        adv_pair(k2 + 5, 15); push_ev(k2 + 7, 0, 0, 0, 0);
        adv_pair(k2 + 9, 0);  push_ev(k2 + 11, 0, 0, 0, 1);
        push_ev(k2 + 13, 0, 0, 1, 1);
        drain();
        chk("wrap_final_shadow", sh_b, 1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
